// File: rtl/sync_tcounter_if.sv
// Control/status bundle for sync_tcounter.
// The master side drives the count controls and load value; the slave side
// (the counter) returns the registered count, the toggle vector and the
// terminal-count flag.
interface sync_tcounter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] t_vec;
  logic             tc;

  modport master (
    output en, up, load, din,
    input  q, t_vec, tc
  );

  modport slave (
    input  en, up, load, din,
    output q, t_vec, tc
  );
endinterface

// File: rtl/sync_tcounter.sv
// sync_tcounter: mod-MODULUS counter whose state is updated as q ^ t_vec,
// so t_vec can feed a bank of T flip-flop cells directly.
// Optional feature macro: TCOUNT_UPDOWN_EN
//   defined   -> bus.up selects increment (1) or decrement (0)
//   undefined -> up-only counter, bus.up is ignored
// Out-of-range q (only reachable via X/force) is treated as terminal so the
// next enabled step always lands back in range.
module sync_tcounter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input logic clk,
  input logic reset,
  sync_tcounter_if.slave bus
);

  // Compares and increments run one bit wider so MODULUS == 2**WIDTH is safe.
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   LAST_EXT = MOD_EXT - (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] LAST     = LAST_EXT[WIDTH-1:0];

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] t_vec;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   din_ext;
  logic [WIDTH:0]   inc_ext;
  logic             at_last;
  logic             at_zero;
  logic             over_top;
  logic             tc;
  logic             unused_carry;

  assign q_ext    = {1'b0, q_reg};
  assign din_ext  = {1'b0, bus.din};
  assign inc_ext  = q_ext + (WIDTH+1)'(1);
  assign at_last  = (q_ext == LAST_EXT);
  assign at_zero  = (q_ext == '0);
  assign over_top = (q_ext >= LAST_EXT);   // last value or out of range

`ifdef TCOUNT_UPDOWN_EN
  logic [WIDTH:0] dec_ext;
  logic           under_bot;
  logic           unused_borrow;

  assign dec_ext       = q_ext - (WIDTH+1)'(1);
  assign under_bot     = at_zero || (q_ext >= MOD_EXT);
  assign unused_borrow = dec_ext[WIDTH];
  assign unused_carry  = inc_ext[WIDTH];

  // Terminal count: top value going up, zero going down.
  assign tc = bus.en & ~bus.load &
              ((bus.up & at_last) | (~bus.up & at_zero));

  // Next-state selection: load beats count beats hold; wrap by compare.
  always_comb begin
    q_next = q_reg;
    if (bus.load) begin
      q_next = (din_ext < MOD_EXT) ? bus.din : LAST;
    end else if (bus.en) begin
      if (bus.up) begin
        q_next = over_top ? '0 : inc_ext[WIDTH-1:0];
      end else begin
        q_next = under_bot ? LAST : dec_ext[WIDTH-1:0];
      end
    end
  end
`else
  logic unused_up;

  assign unused_up    = bus.up;
  assign unused_carry = inc_ext[WIDTH];

  // Terminal count for the up-only build.
  assign tc = bus.en & ~bus.load & at_last;

  // Next-state selection: load beats count beats hold; wrap by compare.
  always_comb begin
    q_next = q_reg;
    if (bus.load) begin
      q_next = (din_ext < MOD_EXT) ? bus.din : LAST;
    end else if (bus.en) begin
      q_next = over_top ? '0 : inc_ext[WIDTH-1:0];
    end
  end
`endif

  // Per-bit toggle requests; forced quiet while reset is held.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_toggle
      assign t_vec[gi] = ~reset & (q_reg[gi] ^ q_next[gi]);
    end
  endgenerate

  // T-flop state update with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_reg ^ t_vec;
    end
  end

  assign bus.q     = q_reg;
  assign bus.t_vec = t_vec;
  assign bus.tc    = tc;

endmodule
